// File: rtl/delay_ctrl_pkg.sv
// Shared encodings and the delay clamp used by the inertial/transport delay controller.
package delay_ctrl_pkg;

  typedef enum logic {
    MODE_INERTIAL  = 1'b0,
    MODE_TRANSPORT = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // A zero delay would make the inertial counter underflow, so it is promoted to one clock.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned max_d);
    if (req == 0) return 1;
    if (req > max_d) return max_d;
    return req;
  endfunction

endpackage

// File: rtl/delay_shift_line.sv
// WIDTH x DEPTH shift register with a selectable tap and a one-cycle flush to a given value.
module delay_shift_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 15,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] flush_val_i,
  input  logic [SEL_W-1:0] tap_sel_i,
  output logic [WIDTH-1:0] tap_o,
  output logic             differs_o
);

  logic [WIDTH-1:0] line_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= flush_val_i;
    end else begin
      line_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  // Entry k holds din sampled k+1 edges ago, so a delay of D reads entry D-1.
  always_comb begin
    tap_o     = line_q[0];
    differs_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(tap_sel_i) == i + 1) tap_o = line_q[i];
      if (i < int'(tap_sel_i) && line_q[i] != flush_val_i) differs_o = 1'b1;
    end
  end

endmodule

// File: rtl/inertial_delay_controller.sv
// Applies a runtime-configurable inertial or transport delay to a WIDTH-bit net.
module inertial_delay_controller
  import delay_ctrl_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int MAX_DELAY   = 15,
  parameter int RESET_DELAY = 10,
  parameter int CNT_W       = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic             cfg_mode,
  output logic             busy,
  output logic             pulse_rejected
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rej_q, rej_d;
  logic             accept;
  logic [WIDTH-1:0] tap;
  logic             line_differs;

  assign cfg_ready      = (mode_q == MODE_TRANSPORT) || (state_q == ST_IDLE);
  assign accept         = cfg_valid && cfg_ready;
  assign dout           = dout_q;
  assign pulse_rejected = rej_q;
  assign busy           = (mode_q == MODE_TRANSPORT) ? line_differs : (state_q == ST_PENDING);

  // Flushing to the current dout keeps the output steady across a config change.
  delay_shift_line #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .SEL_W (CNT_W)
  ) u_line (
    .clk         (clk),
    .rst_n       (reset_n),
    .din_i       (din),
    .flush_i     (accept),
    .flush_val_i (dout_q),
    .tap_sel_i   (delay_q),
    .tap_o       (tap),
    .differs_o   (line_differs)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dout_d  = dout_q;
    rej_d   = 1'b0;
    if (accept) begin
      // din is deliberately ignored on the accept edge; it is evaluated under the new settings next edge.
      mode_d  = mode_e'(cfg_mode);
      delay_d = CNT_W'(clamp_delay(32'(cfg_delay), MAX_DELAY));
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (mode_q == MODE_TRANSPORT) begin
      dout_d = tap;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din != dout_q) begin
            state_d = ST_PENDING;
            pend_d  = din;
            cnt_d   = delay_q - CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (din == dout_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rej_d   = 1'b1;
          end else if (din == pend_q) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              dout_d  = pend_q;
              state_d = ST_IDLE;
            end
          end else begin
            pend_d = din;
            cnt_d  = delay_q - CNT_W'(1);
            rej_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_INERTIAL;
      delay_q <= CNT_W'(RESET_DELAY);
      cnt_q   <= '0;
      pend_q  <= '0;
      dout_q  <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      rej_q   <= rej_d;
    end
  end

endmodule

// File: tb/tb_inertial_delay_controller.sv
// Directed bench for inertial_delay_controller: inertial, glitch, retarget, transport and config cases.
module tb_inertial_delay_controller;

  logic       clk;
  logic       reset_n;
  logic [1:0] din;
  logic [1:0] dout;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_delay;
  logic       cfg_mode;
  logic       busy;
  logic       pulse_rejected;

  int checks = 0;
  int errors = 0;

  inertial_delay_controller #(
    .WIDTH       (2),
    .MAX_DELAY   (15),
    .RESET_DELAY (10)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .din            (din),
    .dout           (dout),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_delay      (cfg_delay),
    .cfg_mode       (cfg_mode),
    .busy           (busy),
    .pulse_rejected (pulse_rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    din       = 2'b00;
    cfg_valid = 1'b0;
    cfg_delay = 4'd0;
    cfg_mode  = 1'b0;
    tick();
    tick();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rej", 32'(pulse_rejected), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    reset_n = 1'b1;
    tick();

    // Inertial D=10 (reset default): 00 -> 10 commits 10 edges after the first sampling edge
    din = 2'b10;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("inr_hold_dout", 32'(dout), 32'h0);
      chk("inr_busy", 32'(busy), 32'h1);
    end
    chk("inr_ready_low", 32'(cfg_ready), 32'h0);
    tick();
    chk("inr_commit", 32'(dout), 32'h2);
    chk("inr_busy_done", 32'(busy), 32'h0);
    tick();
    chk("inr_stay", 32'(dout), 32'h2);

    // Glitch: 11 for two clocks then back to 10
    din = 2'b11;
    tick();
    chk("gl_busy", 32'(busy), 32'h1);
    tick();
    din = 2'b10;
    tick();
    chk("gl_rej", 32'(pulse_rejected), 32'h1);
    chk("gl_idle", 32'(busy), 32'h0);
    tick();
    chk("gl_rej_clr", 32'(pulse_rejected), 32'h0);
    for (int k = 0; k < 10; k++) tick();
    chk("gl_dout", 32'(dout), 32'h2);

    // Retarget: 10 -> 11, two clocks later -> 00 held
    din = 2'b11;
    tick();
    tick();
    din = 2'b00;
    tick();
    chk("rt_rej", 32'(pulse_rejected), 32'h1);
    chk("rt_busy", 32'(busy), 32'h1);
    for (int k = 4; k <= 12; k++) begin
      tick();
      chk("rt_hold_dout", 32'(dout), 32'h2);
      chk("rt_no_rej", 32'(pulse_rejected), 32'h0);
    end
    tick();
    chk("rt_commit", 32'(dout), 32'h0);

    // Transport D=3: a two-clock 01 pulse is replayed with identical width
    chk("tp_ready", 32'(cfg_ready), 32'h1);
    cfg_valid = 1'b1;
    cfg_delay = 4'd3;
    cfg_mode  = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("tp_acc_dout", 32'(dout), 32'h0);
    chk("tp_acc_busy", 32'(busy), 32'h0);
    din = 2'b01;
    tick();
    chk("tp_busy", 32'(busy), 32'h1);
    chk("tp_d1", 32'(dout), 32'h0);
    tick();
    din = 2'b00;
    chk("tp_d2", 32'(dout), 32'h0);
    tick();
    chk("tp_d3", 32'(dout), 32'h0);
    tick();
    chk("tp_d4", 32'(dout), 32'h1);
    tick();
    chk("tp_d5", 32'(dout), 32'h1);
    chk("tp_rej", 32'(pulse_rejected), 32'h0);
    tick();
    chk("tp_d6", 32'(dout), 32'h0);

    // Back to inertial D=10, then request D=4 while a change is pending
    cfg_valid = 1'b1;
    cfg_delay = 4'd10;
    cfg_mode  = 1'b0;
    tick();
    cfg_valid = 1'b0;
    din = 2'b11;
    tick();
    chk("cf_pend", 32'(busy), 32'h1);
    cfg_valid = 1'b1;
    cfg_delay = 4'd4;
    for (int k = 2; k <= 10; k++) begin
      tick();
      chk("cf_ready_low", 32'(cfg_ready), 32'h0);
      chk("cf_hold_dout", 32'(dout), 32'h0);
    end
    tick();
    chk("cf_commit", 32'(dout), 32'h3);
    chk("cf_ready_high", 32'(cfg_ready), 32'h1);
    tick();
    cfg_valid = 1'b0;
    chk("cf_acc_dout", 32'(dout), 32'h3);
    din = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("d4_hold", 32'(dout), 32'h3);
    end
    tick();
    chk("d4_commit", 32'(dout), 32'h1);

    // cfg_delay=0 behaves as D=1
    cfg_valid = 1'b1;
    cfg_delay = 4'd0;
    tick();
    cfg_valid = 1'b0;
    din = 2'b10;
    tick();
    chk("d1_hold", 32'(dout), 32'h1);
    chk("d1_busy", 32'(busy), 32'h1);
    tick();
    chk("d1_commit", 32'(dout), 32'h2);

    // Largest representable request selects MAX_DELAY=15
    cfg_valid = 1'b1;
    cfg_delay = 4'hF;
    tick();
    cfg_valid = 1'b0;
    din = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("dmax_hold", 32'(dout), 32'h2);
    end
    tick();
    chk("dmax_commit", 32'(dout), 32'h0);

    // Accept and din change on the same edge: config first, din seen from the next edge
    cfg_valid = 1'b1;
    cfg_delay = 4'd2;
    din       = 2'b11;
    tick();
    cfg_valid = 1'b0;
    chk("sim_acc_busy", 32'(busy), 32'h0);
    tick();
    chk("sim_pend", 32'(busy), 32'h1);
    tick();
    chk("sim_hold", 32'(dout), 32'h0);
    tick();
    chk("sim_commit", 32'(dout), 32'h3);

    // Reset while a change is pending clears dout immediately
    din = 2'b01;
    tick();
    chk("mr_pend", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_dout", 32'(dout), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_rej", 32'(pulse_rejected), 32'h0);
    chk("mr_ready", 32'(cfg_ready), 32'h1);
    din = 2'b00;
    tick();
    reset_n = 1'b1;
    tick();
    chk("mr_after", 32'(dout), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
